// File: rtl/alu_param.sv
// alu_param: registered ALU with per-accumulator {C,Z,N} flags and a
// conditional-branch evaluator. Shifts by more than one bit are done
// one bit per cycle in a SHIFT state, and the block is busy while they run.
//
// Handshake: a request is taken on a rising Clock edge where iValid=1 and
// oReady=1. iValid while oReady=0 is dropped, not queued. oValid is a
// one-cycle pulse that qualifies oAluData and oBranchTaken. oAluData holds
// its value between pulses. oBranchTaken is 0 whenever oValid is 0.
//
// Ports:
//   Clock, Reset   clock, asynchronous active-high reset
//   iValid         request qualifier
//   iOp            0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR, 6 PASS, 7 BR
//   iAccSel        accumulator whose flags are written or tested
//   iCond          branch condition (0 always,1 Z,2 !Z,3 C,4 !C,5 N,6 !N,7 never)
//   iAluOper1/2    operands; iAluOper2[4:0] is the shift amount
//   oReady         1 when idle
//   oValid         result pulse
//   oAluData       registered result
//   oBranchTaken   registered branch decision
//   oFlags         {C,Z,N} of acc i at [3i+2:3i]
//   oDbgState      FSM state (0 IDLE, 1 SHIFT)
module alu_param #(
  parameter int DATA_W  = 8,
  parameter int NUM_ACC = 2,
  parameter int ACC_W   = 1
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 iValid,
  input  logic [2:0]           iOp,
  input  logic [ACC_W-1:0]     iAccSel,
  input  logic [2:0]           iCond,
  input  logic [DATA_W-1:0]    iAluOper1,
  input  logic [DATA_W-1:0]    iAluOper2,
  output logic                 oReady,
  output logic                 oValid,
  output logic [DATA_W-1:0]    oAluData,
  output logic                 oBranchTaken,
  output logic [3*NUM_ACC-1:0] oFlags,
  output logic                 oDbgState
);

  typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_SHL  = 3'd4;
  localparam logic [2:0] OP_SHR  = 3'd5;
  localparam logic [2:0] OP_PASS = 3'd6;
  localparam logic [2:0] OP_BR   = 3'd7;

  state_t                 state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;        // shift steps still to do
  logic [DATA_W-1:0]      sh_q, sh_d;          // partially shifted value
  logic                   sh_left_q, sh_left_d;
  logic [ACC_W-1:0]       sh_acc_q, sh_acc_d;
  logic                   valid_q, valid_d;
  logic                   br_q, br_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic [3*NUM_ACC-1:0]   flags_q, flags_d;

  logic [4:0]             shamt;
  logic [DATA_W:0]        sum;
  logic [DATA_W-1:0]      step;
  logic                   step_out;
  logic [2:0]             sel_flags;           // {C,Z,N} of iAccSel
  logic                   br_cond;
  logic                   wr_en;
  logic [ACC_W-1:0]       wr_sel;
  logic [DATA_W-1:0]      wr_res;
  logic                   wr_c;

  // Shift amount is the low 5 bits of operand 2; narrow widths zero-extend.
  if (DATA_W >= 5) begin : g_amt
    assign shamt = iAluOper2[4:0];
    if (DATA_W > 5) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^iAluOper2[DATA_W-1:5];
    end
  end else begin : g_amt_narrow
    assign shamt = 5'(iAluOper2);
  end

  always_comb begin
    sel_flags = '0;
    for (int i = 0; i < NUM_ACC; i++) begin
      if (ACC_W'(i) == iAccSel) sel_flags = flags_q[3*i +: 3];
    end
    case (iCond)
      3'd0:    br_cond = 1'b1;
      3'd1:    br_cond = sel_flags[1];
      3'd2:    br_cond = !sel_flags[1];
      3'd3:    br_cond = sel_flags[2];
      3'd4:    br_cond = !sel_flags[2];
      3'd5:    br_cond = sel_flags[0];
      3'd6:    br_cond = !sel_flags[0];
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    sh_left_d = sh_left_q;
    sh_acc_d  = sh_acc_q;
    valid_d   = 1'b0;
    br_d      = 1'b0;
    data_d    = data_q;
    flags_d   = flags_q;
    wr_en     = 1'b0;
    wr_sel    = iAccSel;
    wr_res    = '0;
    wr_c      = 1'b0;
    sum       = '0;
    step      = '0;
    step_out  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (iValid) begin
          case (iOp)
            OP_ADD: begin
              sum    = {1'b0, iAluOper1} + {1'b0, iAluOper2};
              wr_en  = 1'b1;
              wr_res = sum[DATA_W-1:0];
              wr_c   = sum[DATA_W];
            end
            OP_SUB: begin
              wr_en  = 1'b1;
              wr_res = iAluOper1 - iAluOper2;
              wr_c   = (iAluOper1 < iAluOper2);
            end
            OP_AND, OP_OR, OP_PASS: begin
              wr_en  = 1'b1;
              wr_c   = sel_flags[2];
              wr_res = (iOp == OP_AND) ? (iAluOper1 & iAluOper2) :
                       (iOp == OP_OR)  ? (iAluOper1 | iAluOper2) : iAluOper1;
            end
            OP_SHL, OP_SHR: begin
              step     = (iOp == OP_SHL) ? (iAluOper1 << 1) : (iAluOper1 >> 1);
              step_out = (iOp == OP_SHL) ? iAluOper1[DATA_W-1] : iAluOper1[0];
              if (shamt == 5'd0) begin
                wr_en  = 1'b1;
                wr_res = iAluOper1;
                wr_c   = sel_flags[2];
              end else if (shamt == 5'd1) begin
                wr_en  = 1'b1;
                wr_res = step;
                wr_c   = step_out;
              end else begin
                // First step happens on the accepting edge; the rest in SHIFT.
                state_d   = ST_SHIFT;
                cnt_d     = shamt - 5'd1;
                sh_d      = step;
                sh_left_d = (iOp == OP_SHL);
                sh_acc_d  = iAccSel;
              end
            end
            default: begin
              valid_d = 1'b1;
              data_d  = '0;
              br_d    = br_cond;
            end
          endcase
        end
      end
      default: begin
        step     = sh_left_q ? (sh_q << 1) : (sh_q >> 1);
        step_out = sh_left_q ? sh_q[DATA_W-1] : sh_q[0];
        sh_d     = step;
        cnt_d    = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = ST_IDLE;
          wr_en   = 1'b1;
          wr_sel  = sh_acc_q;
          wr_res  = step;
          wr_c    = step_out;
        end
      end
    endcase

    if (wr_en) begin
      valid_d = 1'b1;
      data_d  = wr_res;
      for (int i = 0; i < NUM_ACC; i++) begin
        if (ACC_W'(i) == wr_sel)
          flags_d[3*i +: 3] = {wr_c, (wr_res == '0), wr_res[DATA_W-1]};
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      sh_left_q <= 1'b0;
      sh_acc_q  <= '0;
      valid_q   <= 1'b0;
      br_q      <= 1'b0;
      data_q    <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      sh_left_q <= sh_left_d;
      sh_acc_q  <= sh_acc_d;
      valid_q   <= valid_d;
      br_q      <= br_d;
      data_q    <= data_d;
      flags_q   <= flags_d;
    end
  end

  assign oReady       = (state_q == ST_IDLE);
  assign oValid       = valid_q;
  assign oAluData     = data_q;
  assign oBranchTaken = br_q;
  assign oFlags       = flags_q;
  assign oDbgState    = state_q;

endmodule

// File: tb/tb_alu_param.sv
// Bench for alu_param (DATA_W=8, NUM_ACC=2). Directed vectors push their
// hand-computed result {br, data, flags} plus the cycle on which it must
// appear; a monitor pops and compares on every oValid.
module tb_alu_param;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       iValid = 1'b0;
  logic [2:0] iOp = '0;
  logic [0:0] iAccSel = '0;
  logic [2:0] iCond = '0;
  logic [7:0] iAluOper1 = '0;
  logic [7:0] iAluOper2 = '0;
  logic       oReady, oValid, oBranchTaken, oDbgState;
  logic [7:0] oAluData;
  logic [5:0] oFlags;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [14:0] exp_q[$];
  int          stamp_q[$];

  alu_param #(.DATA_W(8), .NUM_ACC(2), .ACC_W(1)) dut (
    .Clock(Clock), .Reset(Reset), .iValid(iValid), .iOp(iOp), .iAccSel(iAccSel),
    .iCond(iCond), .iAluOper1(iAluOper1), .iAluOper2(iAluOper2), .oReady(oReady),
    .oValid(oValid), .oAluData(oAluData), .oBranchTaken(oBranchTaken),
    .oFlags(oFlags), .oDbgState(oDbgState)
  );

  // clock / reset
  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // driver: waits (bounded) for oReady at a negedge, then presents one request
  task automatic issue(input logic [2:0] op, input logic sel, input logic [2:0] cond,
                       input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic eb, input logic [5:0] ef,
                       input int lat);
    int w = 0;
    while (!oReady && w < 64) begin
      @(negedge Clock);
      w++;
    end
    if (!oReady) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout: got oReady=0, required 1");
    end
    iValid = 1'b1; iOp = op; iAccSel = sel; iCond = cond; iAluOper1 = a; iAluOper2 = b;
    exp_q.push_back({eb, ed, ef});
    stamp_q.push_back(cyc + lat);
    @(posedge Clock);
    @(negedge Clock);
    iValid = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge Clock) begin
    logic [14:0] e;
    int s;
    if (!Reset) begin
      if (oValid) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid: got oValid=1 data=%0h, required no output", oAluData);
        end else begin
          e = exp_q.pop_front();
          s = stamp_q.pop_front();
          check("data", 32'(oAluData), 32'(e[13:6]));
          check("branch", 32'(oBranchTaken), 32'(e[14]));
          check("flags", 32'(oFlags), 32'(e[5:0]));
          check("latency", cyc, s);
        end
      end else begin
        check("branch_idle", 32'(oBranchTaken), 32'd0);
      end
    end
  end

  initial begin
    int t;
    repeat (2) @(negedge Clock);
    check("rst_ready", 32'(oReady), 32'd1);
    check("rst_valid", 32'(oValid), 32'd0);
    check("rst_data", 32'(oAluData), 32'd0);
    check("rst_flags", 32'(oFlags), 32'd0);
    Reset = 1'b0;

    //     op    sel   cond  a      b      data   br    flags     lat
    issue(3'd0, 1'b0, 3'd0, 8'hF0, 8'h20, 8'h10, 1'b0, 6'h04, 1);  // ADD carry
    issue(3'd1, 1'b1, 3'd0, 8'h05, 8'h05, 8'h00, 1'b0, 6'h14, 1);  // SUB zero
    issue(3'd7, 1'b1, 3'd1, 8'hAA, 8'h55, 8'h00, 1'b1, 6'h14, 1);  // BR Z, no hazard
    issue(3'd4, 1'b0, 3'd0, 8'h81, 8'h03, 8'h08, 1'b0, 6'h10, 3);  // SHL by 3
    check("busy_ready_c1", 32'(oReady), 32'd0);
    iValid = 1'b1; iOp = 3'd0; iAccSel = 1'b1; iAluOper1 = 8'hFF; iAluOper2 = 8'hFF;
    @(negedge Clock);
    check("busy_ready_c2", 32'(oReady), 32'd0);
    check("busy_state", 32'(oDbgState), 32'd1);
    iValid = 1'b0;
    issue(3'd5, 1'b0, 3'd0, 8'h01, 8'h01, 8'h00, 1'b0, 6'h16, 1);  // SHR by 1
    issue(3'd1, 1'b1, 3'd0, 8'h00, 8'h01, 8'hFF, 1'b0, 6'h2E, 1);  // SUB borrow
    issue(3'd2, 1'b0, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 6'h2C, 1);  // AND keeps C
    issue(3'd3, 1'b1, 3'd0, 8'h80, 8'h01, 8'h81, 1'b0, 6'h2C, 1);  // OR keeps C
    issue(3'd7, 1'b0, 3'd3, 8'h00, 8'h00, 8'h00, 1'b1, 6'h2C, 1);  // BR C
    issue(3'd7, 1'b1, 3'd2, 8'h00, 8'h00, 8'h00, 1'b1, 6'h2C, 1);  // BR !Z
    issue(3'd7, 1'b1, 3'd7, 8'h00, 8'h00, 8'h00, 1'b0, 6'h2C, 1);  // BR never
    issue(3'd7, 1'b1, 3'd6, 8'h00, 8'h00, 8'h00, 1'b0, 6'h2C, 1);  // BR !N
    issue(3'd7, 1'b1, 3'd5, 8'h00, 8'h00, 8'h00, 1'b1, 6'h2C, 1);  // BR N
    issue(3'd7, 1'b0, 3'd4, 8'h00, 8'h00, 8'h00, 1'b0, 6'h2C, 1);  // BR !C
    issue(3'd6, 1'b1, 3'd0, 8'h00, 8'hAB, 8'h00, 1'b0, 6'h34, 1);  // PASS zero
    issue(3'd4, 1'b0, 3'd0, 8'h55, 8'h00, 8'h55, 1'b0, 6'h34, 1);  // SHL by 0
    issue(3'd5, 1'b0, 3'd0, 8'h80, 8'h08, 8'h00, 1'b0, 6'h36, 8);  // SHR by DATA_W
    issue(3'd4, 1'b1, 3'd0, 8'hFF, 8'h09, 8'h00, 1'b0, 6'h16, 9);  // SHL past width
    issue(3'd0, 1'b1, 3'd0, 8'h12, 8'h01, 8'h13, 1'b0, 6'h06, 1);  // ADD plain

    // reset in the middle of a 5-bit shift
    t = 0;
    while (!oReady && t < 64) begin @(negedge Clock); t++; end
    iValid = 1'b1; iOp = 3'd4; iAccSel = 1'b0; iAluOper1 = 8'h01; iAluOper2 = 8'h05;
    @(posedge Clock);
    @(negedge Clock);
    iValid = 1'b0;
    check("shift_busy", 32'(oReady), 32'd0);
    @(negedge Clock);
    #2 Reset = 1'b1;
    #1;
    check("mid_rst_ready", 32'(oReady), 32'd1);
    check("mid_rst_valid", 32'(oValid), 32'd0);
    check("mid_rst_data", 32'(oAluData), 32'd0);
    check("mid_rst_branch", 32'(oBranchTaken), 32'd0);
    check("mid_rst_flags", 32'(oFlags), 32'd0);
    check("mid_rst_state", 32'(oDbgState), 32'd0);
    exp_q.delete();
    stamp_q.delete();
    @(negedge Clock);
    Reset = 1'b0;
    repeat (6) @(negedge Clock);
    check("post_rst_flags", 32'(oFlags), 32'd0);
    issue(3'd0, 1'b1, 3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 6'h08, 1);  // ADD negative

    t = 0;
    while (exp_q.size() != 0 && t < 200) begin @(negedge Clock); t++; end
    check("drain", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_param.md
ALU_PARAM -- requirements
Module: alu_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand/result width (legal 4..32).
REQ-002 SHALL have parameter NUM_ACC, default 2, number of accumulators with private status flags (legal 2..4).
REQ-003 SHALL have parameter ACC_W, default 1, width of accumulator select (legal: ceil(log2(NUM_ACC)), min 1).
REQ-004 Clock  input  1  single clock; all state rises on posedge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 iValid  input  1  request qualifier; accepted only when oReady=1.
REQ-007 iOp  input  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHL, 5 SHR, 6 PASS, 7 BR.
REQ-008 iAccSel  input  ACC_W  target accumulator for flag update/branch test.
REQ-009 iCond  input  3  BR condition: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 N, 6 !N, 7 never.
REQ-010 iAluOper1  input  DATA_W  first operand (accumulator value).
REQ-011 iAluOper2  input  DATA_W  second operand; shift amount for SHL/SHR (low 5 bits).
REQ-012 oReady  output  1  block can accept a request this cycle.
REQ-013 oValid  output  1  one-cycle pulse: oAluData/oBranchTaken valid.
REQ-014 oAluData  output  DATA_W  registered result.
REQ-015 oBranchTaken  output  1  registered branch decision.
REQ-016 oFlags  output  3*NUM_ACC  {C,Z,N} per accumulator, acc i at bits [3i+2:3i].

Function
REQ-017 SHALL accept a request on a posedge where iValid=1 and oReady=1; iValid while oReady=0 SHALL be ignored, not queued.
REQ-018 SHALL implement FSM IDLE, SHIFT; IDLE->SHIFT on accepted SHL/SHR with amount k>1; SHIFT->IDLE when k steps done; all other accepted ops stay IDLE.
REQ-019 oReady SHALL be 1 in IDLE, 0 in SHIFT.
REQ-020 Non-shift ops and shifts with k<=1 SHALL produce oValid exactly 1 cycle after acceptance; shifts with k>1 SHALL produce oValid k cycles after acceptance, one bit per cycle.
REQ-021 ADD: {C,result} = Oper1+Oper2, DATA_W+1-bit sum.
REQ-022 SUB: result = Oper1-Oper2 mod 2^DATA_W; C = 1 when Oper1 < Oper2 (borrow).
REQ-023 AND/OR/PASS(result=Oper1): C of selected accumulator unchanged.
REQ-024 SHL/SHR: logical shift of Oper1 by k; C = last bit shifted out; k=0 gives result=Oper1, C unchanged; k>=DATA_W gives result 0.
REQ-025 For ADD..PASS, Z = (result==0) and N = result[DATA_W-1], computed from the new result, written to the selected accumulator only, same edge as oValid.
REQ-026 Flags of non-selected accumulators SHALL never change.
REQ-027 BR: oBranchTaken = iCond applied to registered flags of iAccSel at acceptance; oAluData=0; no flag change.
REQ-028 oBranchTaken SHALL be 0 for all non-BR ops; holds last value when oValid=0 is irrelevant but SHALL be 0 when oValid=0.
REQ-029 oAluData SHALL hold its last value while oValid=0.
REQ-030 A BR accepted the cycle after an oValid SHALL observe flags written by that result (no hazard).
REQ-031 Operand, op and select SHALL be captured at acceptance; changes during SHIFT SHALL not affect the result.

Reset
REQ-032 Reset asserted SHALL immediately force: FSM IDLE, oReady=1, oValid=0, oAluData=0, oBranchTaken=0, all oFlags=0, shift counter 0.
REQ-033 Reset during SHIFT SHALL abort the operation; no oValid for it after release.
REQ-034 First request SHALL be accepted on the first posedge with Reset low.

Verification
REQ-035 Reset pulse mid-run -> all outputs 0, oReady=1 asynchronously before next edge.
REQ-036 ADD acc0 0xF0+0x20 (DATA_W=8) -> next cycle oValid=1, oAluData=0x10, acc0 C=1 Z=0 N=0, acc1 flags unchanged.
REQ-037 SUB acc1 0x05-0x05, then BR acc1 cond=1 next cycle -> 0x00, acc1 Z=1 C=0; then oBranchTaken=1, oAluData=0x00.
REQ-038 SHL acc0 0x81 by 3 -> oReady=0 for 2 cycles, oValid at cycle 3, oAluData=0x08, acc0 C=0 Z=0 N=0; iValid pulsed while busy ignored (single oValid).
REQ-039 SHR acc0 0x01 by 1 then SUB 0x00-0x01 on acc1 -> 0x00 C0=1 Z0=1; then 0xFF C1=1 N1=1.
REQ-040 Reset during SHL by 5 at cycle 2 -> no oValid ever, oFlags=0, next request processed normally.
